// File: rtl/increment_program_counter.sv
// Next-PC generator: a 4-bit PC register fed back through a 5-bit ripple-carry adder that adds STEP.
// Optional build macro IPC_SATURATE_EN: the PC holds at its last value once the sum carries out.
module increment_program_counter #(
  parameter logic [3:0] STEP = 4'd1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] sh_reg_out,
  output logic [4:0] adder_out
);

  logic [4:0] carry;
  logic [3:0] sum;
  logic [3:0] next_pc;

  // Four full-adder cells chained through carry; carry-in is tied low.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i]       = sh_reg_out[i] ^ STEP[i] ^ carry[i];
      carry[i + 1] = (sh_reg_out[i] & STEP[i]) | (carry[i] & (sh_reg_out[i] ^ STEP[i]));
    end
    adder_out = {carry[4], sum};
  end

  always_comb begin
`ifdef IPC_SATURATE_EN
    next_pc = adder_out[4] ? sh_reg_out : adder_out[3:0];
`else
    next_pc = adder_out[3:0];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sh_reg_out <= '0;
    else        sh_reg_out <= next_pc;
  end

endmodule

// File: tb/tb_increment_program_counter.sv
// Scoreboarded random-reset bench for increment_program_counter, STEP = 1 and STEP = 5 side by side.
module tb_increment_program_counter;

  logic       clk;
  logic       reset;
  logic [3:0] pc1, pc5;
  logic [4:0] sum1, sum5;

  typedef struct {
    logic [3:0] s1;
    logic [4:0] a1;
    logic [3:0] s5;
    logic [4:0] a5;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit done   = 0;

  increment_program_counter #(.STEP(4'd1)) dut1 (
    .clk(clk), .reset(reset), .sh_reg_out(pc1), .adder_out(sum1)
  );
  increment_program_counter #(.STEP(4'd5)) dut5 (
    .clk(clk), .reset(reset), .sh_reg_out(pc5), .adder_out(sum5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC after n counting edges since reset release.
  function automatic int unsigned model_pc(int unsigned step, int unsigned n);
    int unsigned v;
    v = n * step;
`ifdef IPC_SATURATE_EN
    if (v > (15 / step) * step) v = (15 / step) * step;
    return v;
`else
    return v % 16;
`endif
  endfunction

  function automatic exp_t make_exp(int unsigned n);
    exp_t e;
    int unsigned p1, p5;
    p1 = model_pc(1, n);
    p5 = model_pc(5, n);
    e.s1 = 4'(p1);
    e.a1 = 5'(p1 + 1);
    e.s5 = 4'(p5);
    e.a5 = 5'(p5 + 5);
    return e;
  endfunction

  task automatic check(string name, logic [4:0] act, logic [4:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Monitor: compares DUT outputs against the oldest pending expectation on each falling edge.
  always @(negedge clk) begin
    if (!done && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("pc_step1",  {1'b0, pc1}, {1'b0, e.s1});
      check("sum_step1", sum1,        e.a1);
      check("pc_step5",  {1'b0, pc5}, {1'b0, e.s5});
      check("sum_step5", sum5,        e.a5);
    end
  end

  initial begin
    int unsigned n;
    n = 0;
    reset = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk);
      if (reset) n++;
      #1;
      if (cyc < 3)        reset = 1'b0;
      else if (cyc < 40)  reset = 1'b1;
      else if (cyc == 40) reset = 1'b0;
      else if (cyc < 43)  reset = 1'b1;
      else if (cyc < 60)  reset = 1'b1;
      else if ($urandom_range(0, 19) == 0) reset = 1'b0;
      else reset = 1'b1;
      if (!reset) n = 0;
      q.push_back(make_exp(n));
    end
    @(negedge clk);
    #1;
    done = 1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
